// File: rtl/jtkunio_objdma_pkg.sv
// Shared definitions for the sprite object-RAM DMA engine.
// The video top and the bench use these values too.
package jtkunio_objdma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_COPY,
      ST_DONE
   } dma_state_t;

   // Default table geometry: 2^AW bytes copied from SRC_BASE upward
   localparam int          OBJDMA_AW       = 8;
   localparam int          OBJDMA_LEN      = 1 << OBJDMA_AW;
   localparam logic [11:0] OBJDMA_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtkunio_objdma.sv
// Object-RAM DMA: requests the CPU bus and copies 2^AW sprite attribute
// bytes from shared CPU RAM into the private object table.
module jtkunio_objdma
   import jtkunio_objdma_pkg::*;
#(
   parameter int          AW       = OBJDMA_AW,
   parameter logic [11:0] SRC_BASE = OBJDMA_SRC_BASE
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          dma_go,
   input  logic          busak_n,
   input  logic [7:0]    dma_din,
   output logic          busrq,
   output logic [11:0]   dma_addr,
   output logic          dma_rd,
   output logic [AW-1:0] obj_addr,
   output logic [7:0]    obj_din,
   output logic          obj_we,
   output logic          busy,
   output logic          done
);

   dma_state_t  state;
   logic [AW:0] cnt;
   logic        pend;
   logic        in_copy;

   assign in_copy = (state == ST_COPY);

   // Write strobe and done are qualified by cen so they land exactly on a
   // cen clk; the byte written at count k is the one fetched at count k-1.
   assign obj_we   = cen & in_copy & ~busak_n & (cnt != '0);
   assign done     = cen & (state == ST_DONE);
   assign dma_rd   = in_copy & ~cnt[AW];
   assign dma_addr = in_copy ? SRC_BASE + 12'(cnt[AW-1:0]) : SRC_BASE;
   assign obj_din  = in_copy ? dma_din : 8'h00;

   // Request/copy sequencer; dma_go is latched into pend on any clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         busrq    <= 1'b0;
         busy     <= 1'b0;
         pend     <= 1'b0;
         cnt      <= '0;
         obj_addr <= '0;
      end else begin
         if (cen && pend && (state == ST_IDLE || state == ST_DONE))
            pend <= 1'b0;
         if (dma_go)
            pend <= 1'b1;
         if (cen) begin
            case (state)
               ST_IDLE: begin
                  if (pend) begin
                     state <= ST_REQ;
                     busy  <= 1'b1;
                     busrq <= 1'b1;
                  end
               end
               ST_REQ: begin
                  busrq <= 1'b1;
                  if (!busak_n) begin
                     state    <= ST_COPY;
                     cnt      <= '0;
                     obj_addr <= '0;
                  end
               end
               ST_COPY: begin
                  // A withdrawn grant freezes the count, address and write pointer
                  if (!busak_n) begin
                     if (cnt != '0)
                        obj_addr <= obj_addr + AW'(1);
                     if (cnt[AW])
                        state <= ST_DONE;
                     else
                        cnt <= cnt + (AW+1)'(1);
                  end
               end
               ST_DONE: begin
                  busrq <= 1'b0;
                  if (pend) begin
                     state <= ST_REQ;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtkunio_objdma.sv
// Directed bench for jtkunio_objdma: a default-base instance for most
// scenarios plus an F80-based instance that exercises address wrap.
module tb_jtkunio_objdma;
   import jtkunio_objdma_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen;
   logic [2:0]  cdiv = 3'd0;
   logic        dma_go = 1'b0, dma_go_w = 1'b0;
   logic        busak_n = 1'b1;
   logic [7:0]  dma_din = 8'h00, din_w = 8'h00;
   logic        busrq, dma_rd, obj_we, busy, done;
   logic [11:0] dma_addr;
   logic [7:0]  obj_addr, obj_din;
   logic        busrq_w, dma_rd_w, obj_we_w, busy_w, done_w;
   logic [11:0] dma_addr_w;
   logic [7:0]  obj_addr_w, obj_din_w;

   int nvec = 0, nerr = 0;
   int cen_cnt = 0, we_total = 0, done_cnt = 0, start_cen = 0, done_cen = 0;
   int we_w = 0, done_w_cnt = 0, grant_idx = 0;
   bit started = 1'b0;
   logic [7:0]  exp_addr = 8'h00, exp_addr_w = 8'h00;
   logic [11:0] exp_src_w = 12'hF80;

   always #5 clk = ~clk;

   // 6 MHz enable: one clk in eight
   always @(posedge clk) cdiv <= cdiv + 3'd1;
   assign cen = (cdiv == 3'd7);

   jtkunio_objdma u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .busak_n(busak_n),
      .dma_din(dma_din), .busrq(busrq), .dma_addr(dma_addr), .dma_rd(dma_rd),
      .obj_addr(obj_addr), .obj_din(obj_din), .obj_we(obj_we), .busy(busy), .done(done)
   );

   jtkunio_objdma #(.AW(8), .SRC_BASE(12'hF80)) u_wrap (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go_w), .busak_n(busak_n),
      .dma_din(din_w), .busrq(busrq_w), .dma_addr(dma_addr_w), .dma_rd(dma_rd_w),
      .obj_addr(obj_addr_w), .obj_din(obj_din_w), .obj_we(obj_we_w), .busy(busy_w), .done(done_w)
   );

   // Source pattern: upper nibble folded in so wrapped reads are distinguishable
   function automatic logic [7:0] srcByte(input logic [11:0] a);
      return a[7:0] ^ 8'h5A ^ {a[11:8], 4'h0};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Shared RAM: output register follows the address only while the bus is ours
   always @(posedge clk) begin
      if (cen && !busak_n) begin
         dma_din <= srcByte(dma_addr);
         din_w   <= srcByte(dma_addr_w);
      end
   end

   // Scoreboard: every object-table write and every wrapped source fetch
   always @(negedge clk) begin
      if (cen) cen_cnt++;
      if (obj_we) begin
         checkOutput("we_cen", 32'(cen), 32'd1);
         checkOutput("we_addr", 32'(obj_addr), 32'(exp_addr));
         checkOutput("we_data", 32'(obj_din), 32'(srcByte(OBJDMA_SRC_BASE + 12'(obj_addr))));
         exp_addr++;
         we_total++;
      end
      if (cen && dma_rd && !busak_n && !started) begin
         started   = 1'b1;
         start_cen = cen_cnt;
      end
      if (done) begin
         checkOutput("done_cen", 32'(cen), 32'd1);
         done_cnt++;
         done_cen = cen_cnt;
      end
      if (obj_we_w) begin
         checkOutput("w_addr", 32'(obj_addr_w), 32'(exp_addr_w));
         checkOutput("w_data", 32'(obj_din_w), 32'(srcByte(12'hF80 + 12'(obj_addr_w))));
         exp_addr_w++;
         we_w++;
      end
      if (cen && dma_rd_w && !busak_n) begin
         checkOutput("w_src", 32'(dma_addr_w), 32'(exp_src_w));
         exp_src_w++;
      end
      if (done_w) done_w_cnt++;
   end

   task automatic applyStimulus(input bit both);
      @(posedge clk); #1;
      dma_go = 1'b1;
      dma_go_w = both;
      @(posedge clk); #1;
      dma_go = 1'b0;
      dma_go_w = 1'b0;
   endtask

   // Returns just after a posedge, with the next posedge being the n-th cen edge
   task automatic waitCens(input int n);
      repeat (n) begin
         do begin @(posedge clk); #1; end while (!cen);
      end
   endtask

   task automatic waitBusrq();
      int n = 0;
      while (!busrq && n < 500) begin @(posedge clk); #1; n++; end
      checkOutput("busrq_rise", 32'(busrq), 32'd1);
   endtask

   task automatic waitWe(input int k);
      int n = 0;
      while (we_total < k && n < 6000) begin @(posedge clk); #1; n++; end
      checkOutput("we_reach", 32'(we_total), 32'(k));
   endtask

   task automatic waitDone(input int k);
      int n = 0;
      while (done_cnt < k && n < 6000) begin @(posedge clk); #1; n++; end
      checkOutput("done_reach", 32'(done_cnt), 32'(k));
   endtask

   task automatic resetScore();
      exp_addr = 8'h00;
      we_total = 0;
      done_cnt = 0;
      started  = 1'b0;
   endtask

   task automatic grantNow();
      grant_idx = cen_cnt + 1;
      busak_n = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busrq", 32'(busrq), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_addr", 32'(dma_addr), 32'h000);
      checkOutput("rst_waddr", 32'(dma_addr_w), 32'hF80);
      checkOutput("rst_oaddr", 32'(obj_addr), 32'd0);
      #2 rst_n = 1'b1;

      // Basic copy, both instances in lockstep (the second one wraps)
      resetScore();
      applyStimulus(1'b1);
      waitBusrq();
      checkOutput("t1_busy", 32'(busy), 32'd1);
      checkOutput("t1_rd_req", 32'(dma_rd), 32'd0);
      waitCens(2);
      grantNow();
      waitDone(1);
      checkOutput("t1_we_n", 32'(we_total), 32'd256);
      checkOutput("t1_start", 32'(start_cen), 32'(grant_idx + 1));
      checkOutput("t1_len", 32'(done_cen - start_cen), 32'(OBJDMA_LEN + 1));
      checkOutput("t1_busrq", 32'(busrq), 32'd0);
      checkOutput("t1_busy_end", 32'(busy), 32'd0);
      checkOutput("w_we_n", 32'(we_w), 32'd256);
      checkOutput("w_done", 32'(done_w_cnt), 32'd1);
      checkOutput("w_src_end", 32'(exp_src_w), 32'h080);
      busak_n = 1'b1;

      // Grant latency of 20 cens
      resetScore();
      applyStimulus(1'b0);
      waitBusrq();
      for (int i = 0; i < 20; i++) begin
         waitCens(1);
         checkOutput("t2_rd_wait", 32'(dma_rd), 32'd0);
      end
      waitCens(1);
      checkOutput("t2_no_we", 32'(we_total), 32'd0);
      grantNow();
      waitDone(1);
      checkOutput("t2_start", 32'(start_cen), 32'(grant_idx + 1));
      checkOutput("t2_len", 32'(done_cen - start_cen), 32'd257);
      checkOutput("t2_we_n", 32'(we_total), 32'd256);
      busak_n = 1'b1;

      // Bus withdrawn for 7 cens at cnt=100
      resetScore();
      applyStimulus(1'b0);
      waitBusrq();
      waitCens(1);
      grantNow();
      waitWe(99);
      busak_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         waitCens(1);
         checkOutput("t3_hold_rd", 32'(dma_rd), 32'd1);
         checkOutput("t3_hold_rq", 32'(busrq), 32'd1);
         checkOutput("t3_hold_addr", 32'(dma_addr), 32'd100);
      end
      waitCens(1);
      checkOutput("t3_hold_we", 32'(we_total), 32'd99);
      busak_n = 1'b0;
      waitDone(1);
      checkOutput("t3_len", 32'(done_cen - start_cen), 32'd264);
      checkOutput("t3_we_n", 32'(we_total), 32'd256);
      busak_n = 1'b1;

      // Two strobes during COPY collapse into one extra transfer
      resetScore();
      applyStimulus(1'b0);
      waitBusrq();
      waitCens(1);
      grantNow();
      waitWe(10);
      applyStimulus(1'b0);
      waitCens(3);
      applyStimulus(1'b0);
      waitDone(1);
      checkOutput("t4_busy_mid", 32'(busy), 32'd1);
      waitWe(300);
      checkOutput("t4_busy_2nd", 32'(busy), 32'd1);
      waitDone(2);
      checkOutput("t4_we_n", 32'(we_total), 32'd512);
      checkOutput("t4_busy_end", 32'(busy), 32'd0);
      waitCens(20);
      checkOutput("t4_no_third", 32'(done_cnt), 32'd2);
      checkOutput("t4_idle_rq", 32'(busrq), 32'd0);
      busak_n = 1'b1;

      // Asynchronous reset at cnt=50, off the clock edges
      resetScore();
      applyStimulus(1'b0);
      waitBusrq();
      waitCens(1);
      grantNow();
      waitWe(49);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t5_busrq", 32'(busrq), 32'd0);
      checkOutput("t5_rd", 32'(dma_rd), 32'd0);
      checkOutput("t5_we", 32'(obj_we), 32'd0);
      checkOutput("t5_done", 32'(done), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_addr", 32'(dma_addr), 32'h000);
      checkOutput("t5_oaddr", 32'(obj_addr), 32'd0);
      checkOutput("t5_odin", 32'(obj_din), 32'd0);
      #28 rst_n = 1'b1;
      busak_n = 1'b1;
      waitCens(10);
      checkOutput("t5_no_done", 32'(done_cnt), 32'd0);
      checkOutput("t5_partial", 32'(we_total), 32'd49);
      resetScore();
      applyStimulus(1'b0);
      waitBusrq();
      waitCens(1);
      grantNow();
      waitDone(1);
      checkOutput("t5_we_n", 32'(we_total), 32'd256);
      checkOutput("t5_len", 32'(done_cen - start_cen), 32'd257);
      busak_n = 1'b1;

      waitCens(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/jtkunio_objdma.md
Name: jtkunio_objdma

Overview:
Object-RAM DMA engine used by the video stage's sprite path. A CPU write strobe (dma_go) triggers a bus request to the main CPU. Once the bus is granted, the engine copies a fixed-size block of sprite attribute bytes from shared CPU RAM into the private object table that the sprite renderer scans. It drives the busrq/busak_n handshake and produces a done strobe.

Parameters:
AW, 8, object table address width; transfer length is 2^AW bytes
SRC_BASE, 12'h000, CPU-bus byte address of the first source byte

Ports:
clk        in   1     system clock (48 MHz domain)
rst_n      in   1     asynchronous active-low reset
cen        in   1     clock enable (6 MHz); all state advances only when cen=1
dma_go     in   1     one-clk strobe from the CPU register decode; starts a transfer
busak_n    in   1     CPU bus acknowledge, active low
dma_din    in   8     source RAM read data; valid one cen after dma_addr is held while granted
busrq      out  1     bus request to CPU, active high
dma_addr   out  12    source read address
dma_rd     out  1     source read enable
obj_addr   out  AW    object table write address
obj_din    out  8     object table write data
obj_we     out  1     object table write strobe, one clk wide, coincident with cen
busy       out  1     high from acceptance of dma_go until done
done       out  1     one-clk strobe, coincident with cen, at transfer end

Behaviour:
- Reset (async, rst_n=0): state IDLE; busrq=0, dma_rd=0, obj_we=0, done=0, busy=0, dma_addr=SRC_BASE, obj_addr=0, obj_din=0, cnt=0, pend=0.
- dma_go is sampled on every clk, independent of cen. It sets the pend flag, so a strobe between cens is never lost. Multiple strobes before service collapse into one.
- FSM states: IDLE, REQ, COPY, DONE.
- IDLE: on a cen with pend=1, clear pend, go to REQ, set busy=1.
- REQ: busrq=1. On a cen with busak_n=0, go to COPY with cnt=0 and dma_addr=SRC_BASE.
- COPY: busrq=1. cnt is AW+1 bits wide. dma_addr=SRC_BASE+cnt[AW-1:0], truncated to 12 bits (wrap-around allowed). dma_rd=1 while cnt<2^AW.
  - Advancing cen (cen=1 and busak_n=0): if cnt>=1, assert obj_we, with obj_addr=cnt-1 and obj_din=dma_din. Then cnt increments.
  - When an advancing cen occurs at cnt=2^AW, the last byte is written and the FSM goes to DONE.
  - Total is exactly 2^AW+1 advancing cens, i.e. 257 for AW=8.
- Stall: on a cen with busak_n=1 in COPY, nothing advances. cnt, dma_addr and the pipeline hold; obj_we=0; dma_rd stays 1; busrq stays 1. On regrant, dma_din reflects the held address, so no byte is skipped or duplicated.
- DONE: on the next cen, set busrq=0, done=1 for that clk, and busy=0.
  - If pend=1, go to REQ instead of IDLE. busy then stays 1, but done still pulses.
- dma_go arriving in REQ/COPY/DONE only sets pend; it never restarts the current transfer.
- busrq deasserts only in DONE or on reset. busak_n low while in IDLE is ignored.
- Reset during COPY aborts immediately. The object table keeps the partial contents; no done pulse is produced.
- obj_we is never asserted on a clk without cen.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/COPY/DONE) and the default transfer-length constant, so that the video top and the bench use the same values.
- No sub-module; a single flat module. The object table RAM stays in the video stage (jtframe dual-port RAM instance outside this block).

Test Plan:
1. Basic copy: source RAM[i]=i^8'h5A; pulse dma_go; busak_n=0 two cens after busrq rises -> 256 obj_we pulses at obj_addr 0..255 with matching data; done exactly 257 cens after the first granted cen; busrq=0 at done.
2. Grant latency: hold busak_n=1 for 20 cens after busrq -> no dma_rd progress and no obj_we; the copy starts on the first cen with busak_n=0.
3. Mid-copy bus withdrawal: raise busak_n for 7 cens at cnt=100 -> obj_addr sequence is continuous 0..255; byte 99/100 data correct; total 264 cens from grant to done.
4. Re-trigger: pulse dma_go twice during COPY -> exactly one extra transfer; busy stays 1 through both; two done pulses; 512 obj_we in total.
5. Async reset at cnt=50 (rst_n low for 3 clks, not cen-aligned) -> all outputs at reset values immediately; no done; a fresh dma_go gives a full 256-byte copy.
6. Wrap: SRC_BASE=12'hF80 -> dma_addr runs F80..FFF then 000..07F; data matches the wrapped source.
